imem_loader: RTL and testbench

//   Boot-time writer for the instruction memory. Accepts a length-prefixed byte

---
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Receives a length-prefixed byte stream (16-bit little-endian word count,
// then 4 bytes per word, LSB first). Each word is written to i-mem with a
// single-cycle write pulse. busy is high from start until DONE or ERR, so the
// core can be held in reset while loading.
//
// Optional feature macro: IMEM_LDR_CHECKSUM_EN
//   When defined, the image is followed by one checksum byte. It must equal the
//   XOR of all data bytes, or the load ends in ERR. Writes already made stay.
//
// Ports:
//   clk       in   1   clock, all state on rising edge
//   rst       in   1   asynchronous active-low reset
//   start     in   1   begin a load; honoured only in IDLE, DONE or ERR
//   in_valid  in   1   byte-stream valid
//   in_data   in   8   byte-stream data
//   in_ready  out  1   loader accepts a byte this cycle
//   we0       out  1   i-mem write enable, one pulse per word
//   wr_addr0  out  32  i-mem write byte address
//   wr_din0   out  32  i-mem write data
//   busy      out  1   load in progress
//   done      out  1   load completed, held until next start
//   err       out  1   load rejected, held until next start

module imem_loader #(
    parameter int          MAX_WORDS = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we0,
    output logic [31:0] wr_addr0,
    output logic [31:0] wr_din0,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef IMEM_LDR_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;       // first three bytes of the word being assembled
    logic        accept;
    logic        start_ok;
    logic [15:0] len_full;
    logic        last_word;
`ifdef IMEM_LDR_CHECKSUM_EN
    logic [7:0]  xor_acc;
`endif

    assign accept    = in_valid & in_ready;
    assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign len_full  = {in_data, len[7:0]};
    assign last_word = (word_cnt + 16'd1) == len;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN0;
            end
            S_LEN0: begin
                if (accept) state_nxt = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if (len_full == 16'd0)                 state_nxt = S_DONE;
                    else if (len_full > 16'(MAX_WORDS))    state_nxt = S_ERR;
                    else                                   state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
`ifdef IMEM_LDR_CHECKSUM_EN
                state_nxt = last_word ? S_CHK : S_DATA;
`else
                state_nxt = last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef IMEM_LDR_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_nxt = (in_data == xor_acc) ? S_DONE : S_ERR;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready = 1'b0;
        we0      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_LEN0, S_LEN1, S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef IMEM_LDR_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            S_WRITE: begin
                we0  = 1'b1;
                busy = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, word assembly, write address/data registers.
    // wr_addr0/wr_din0 are loaded on the 4th byte so they are valid during WRITE
    // and then simply hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len      <= 16'd0;
            word_cnt <= 16'd0;
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
            wr_addr0 <= BASE_ADDR;
            wr_din0  <= 32'd0;
`ifdef IMEM_LDR_CHECKSUM_EN
            xor_acc  <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                word_cnt <= 16'd0;
                byte_cnt <= 2'd0;
`ifdef IMEM_LDR_CHECKSUM_EN
                xor_acc  <= 8'd0;
`endif
            end
            if (state == S_LEN0 && accept) len[7:0]  <= in_data;
            if (state == S_LEN1 && accept) len[15:8] <= in_data;
            if (state == S_DATA && accept) begin
                shift    <= {in_data, shift[23:8]};
                byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
`ifdef IMEM_LDR_CHECKSUM_EN
                xor_acc  <= xor_acc ^ in_data;
`endif
                if (byte_cnt == 2'd3) begin
                    wr_din0  <= {in_data, shift};
                    wr_addr0 <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                end
            end
            if (state == S_WRITE) word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        we0;
    logic [31:0] wr_addr0;
    logic [31:0] wr_din0;
    logic        busy;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic        wr_rdy[$];

    imem_loader #(.MAX_WORDS(16), .BASE_ADDR(32'h0000_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we0      (we0),
        .wr_addr0 (wr_addr0),
        .wr_din0  (wr_din0),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Record every write seen, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (we0 === 1'b1) begin
            wa.push_back(wr_addr0);
            wd.push_back(wr_din0);
            wc.push_back(cyc);
            wr_rdy.push_back(in_ready);
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); wr_rdy.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns on the falling edge after it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 40; t++) begin
            if (in_ready === 1'b1) begin
                @(negedge clk);
                got = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL send_byte_timeout byte=%02h in_ready never seen", b);
        end
    endtask

    task automatic test_reset();
        logic [7:0] img[4] = '{8'h02, 8'h00, 8'h78, 8'h56};
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, we0, busy, done, err} !== 5'b0 || wr_addr0 !== 32'h0 || wr_din0 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state rdy/we/busy/done/err=%b addr=%h din=%h required 00000 0 0",
                     {in_ready, we0, busy, done, err}, wr_addr0, wr_din0);
        end
        rst = 1'b1;
        clear_log();
        pulse_start();
        foreach (img[i]) send_byte(img[i], 0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, we0, busy, done, err} !== 5'b0 || wr_addr0 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_data rdy/we/busy/done/err=%b addr=%h required 00000 addr 0",
                     {in_ready, we0, busy, done, err}, wr_addr0);
        end
        @(negedge clk) rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h34;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || wa.size() != 0) begin
            miscompares++;
            $display("FAIL reset_needs_start busy=%b in_ready=%b writes=%0d required 0 0 0",
                     busy, in_ready, wa.size());
        end
    endtask

    // Two-word load; gap_max>0 adds random idle cycles between bytes.
    task automatic run_load2(input string name, input int gap_max, input bit good_chk);
        logic [7:0]  img[10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        logic [31:0] exp_a[2] = '{32'h0, 32'h4};
        logic [31:0] exp_d[2] = '{32'h1234_5678, 32'hDEAD_BEEF};
        logic [7:0]  chk = 8'h00;
        clear_log();
        pulse_start();
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after_start busy=%b in_ready=%b done=%b err=%b required 1 1 0 0",
                     name, busy, in_ready, done, err);
        end
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
            if (i >= 2) chk ^= img[i];
        end
        vectors++;
        if (we0 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_write_latency we0=%b required 1", name, we0);
        end
        @(negedge clk);
`ifdef IMEM_LDR_CHECKSUM_EN
        send_byte(good_chk ? chk : ~chk, 0);
`endif
        vectors++;
        if (done !== good_chk || err !== !good_chk || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_end done=%b err=%b busy=%b required %b %b 0",
                     name, done, err, busy, good_chk, !good_chk);
        end
        vectors++;
        if (wa.size() != 2) begin
            miscompares++;
            $display("FAIL %s_write_count got=%0d required 2", name, wa.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (wa[k] !== exp_a[k] || wd[k] !== exp_d[k] || wr_rdy[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_write%0d addr=%h data=%h rdy=%b required %h %h 0",
                             name, k, wa[k], wd[k], wr_rdy[k], exp_a[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_load2();
        run_load2("load2", 0, 1'b1);
    endtask

    task automatic test_backpressure();
        run_load2("backpressure", 3, 1'b1);
    endtask

    task automatic test_len0();
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_done done=%b busy=%b err=%b required 1 0 0", done, busy, err);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (wa.size() != 0) begin
            miscompares++;
            $display("FAIL len0_no_write writes=%0d required 0", wa.size());
        end
    endtask

    task automatic test_len17();
        logic [7:0] w[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_log();
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        vectors++;
        if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL len17_err err=%b in_ready=%b busy=%b done=%b required 1 0 0 0",
                     err, in_ready, busy, done);
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (wa.size() != 0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL len17_no_write writes=%0d err=%b required 0 1", wa.size(), err);
        end
        pulse_start();
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL len17_rearm err=%b busy=%b required 0 1", err, busy);
        end
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        foreach (w[i]) send_byte(w[i], 0);
        @(negedge clk);
`ifdef IMEM_LDR_CHECKSUM_EN
        send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0);
`endif
        vectors++;
        if (done !== 1'b1 || wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'hDDCC_BBAA) begin
            miscompares++;
            $display("FAIL rearm_load done=%b writes=%0d required done 1, one write (0,ddccbbaa)",
                     done, wa.size());
        end
    endtask

    // Largest accepted image: 16 words, back to back, 5 cycles per word.
    task automatic test_back_to_back();
        logic [7:0] chk = 8'h00;
        clear_log();
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i), 0);
            chk ^= 8'(i);
        end
        @(negedge clk);
`ifdef IMEM_LDR_CHECKSUM_EN
        send_byte(chk, 0);
`endif
        vectors++;
        if (done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL max_len_done done=%b err=%b required 1 0", done, err);
        end
        vectors++;
        if (wa.size() != 16) begin
            miscompares++;
            $display("FAIL max_len_count writes=%0d required 16", wa.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                logic [31:0] ed;
                ed = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                vectors++;
                if (wa[k] !== 32'(4*k) || wd[k] !== ed) begin
                    miscompares++;
                    $display("FAIL max_len_write%0d addr=%h data=%h required %h %h",
                             k, wa[k], wd[k], 32'(4*k), ed);
                end
                if (k > 0) begin
                    vectors++;
                    if (wc[k] - wc[k-1] != 5) begin
                        miscompares++;
                        $display("FAIL throughput_word%0d spacing=%0d required 5",
                                 k, wc[k] - wc[k-1]);
                    end
                end
            end
        end
    endtask

    // A start pulse in the middle of a load must not disturb it.
    task automatic test_start_ignored();
        logic [7:0] img[10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i], 0);
            if (i == 3) pulse_start();
        end
        @(negedge clk);
`ifdef IMEM_LDR_CHECKSUM_EN
        send_byte(8'h2A, 0);
`endif
        vectors++;
        if (done !== 1'b1 || wa.size() != 2 || wd[0] !== 32'h1234_5678 || wd[1] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL start_ignored done=%b writes=%0d required done 1, 2 writes",
                     done, wa.size());
        end
    endtask

`ifdef IMEM_LDR_CHECKSUM_EN
    task automatic test_bad_checksum();
        run_load2("bad_checksum", 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_load2();
        test_backpressure();
        test_len0();
        test_len17();
        test_back_to_back();
        test_start_ignored();
`ifdef IMEM_LDR_CHECKSUM_EN
        test_bad_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
